// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared constants, receive FSM state type and baud divisor helper for the
// UART receive path.
//   OVERSAMPLE : ticks per bit time
//   DATA_BITS  : payload bits per frame (8N1)
//   SAMPLE_LO/SAMPLE_HI : first and last tick of the 3-sample majority vote;
//                         the bit decision is taken at SAMPLE_HI
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int OVERSAMPLE = 16;
  localparam int DATA_BITS  = 8;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_HI  = 9;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Rounded clocks-per-tick: round(clk_freq / (baud_rate * OVERSAMPLE)).
  function automatic int calc_divisor(input int clk_freq, input int baud_rate);
    int den;
    den = baud_rate * OVERSAMPLE;
    return (clk_freq + den / 2) / den;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Show-ahead FIFO for received bytes. The head entry is always visible on
// RdData; RdEn pops it. A write while full is accepted only when a pop happens
// in the same cycle, otherwise the byte is discarded (the caller flags it).
//   Clock  : system clock, rising edge
//   Reset  : asynchronous, active-high; flushes the FIFO
//   WrEn   : push WrData
//   WrData : byte to push
//   RdEn   : pop head (ignored while Empty)
//   RdData : head entry (show-ahead)
//   Empty  : no entries held
//   Full   : DEPTH entries held
// DEPTH must be a power of two (pointers wrap by natural overflow), >= 2.
// -----------------------------------------------------------------------------
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 WrEn,
  input  logic [DATA_BITS-1:0] WrData,
  input  logic                 RdEn,
  output logic [DATA_BITS-1:0] RdData,
  output logic                 Empty,
  output logic                 Full
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W:0]       r_count;
  logic                 w_do_rd;
  logic                 w_do_wr;

  assign Empty   = (r_count == '0);
  assign Full    = (r_count == (PTR_W + 1)'(DEPTH));
  assign w_do_rd = RdEn && !Empty;
  // A pop in the same cycle frees the slot the push needs.
  assign w_do_wr = WrEn && (!Full || w_do_rd);
  assign RdData  = r_mem[r_rd_ptr];

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      // NOTE: storage is reset too so the head reads 0 out of reset; this is
      // only cheap because the array is a handful of flops, not a RAM macro.
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout clocked logic, so every flop
      // sees the pre-edge value of every other flop regardless of statement order.
      if (w_do_wr) begin
        r_mem[r_wr_ptr] <= WrData;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + (PTR_W + 1)'(1);
        2'b01:   r_count <= r_count - (PTR_W + 1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// -----------------------------------------------------------------------------
// uart_receiver
// 8N1 serial receiver with 16x oversampling, 3-sample majority voting, a
// show-ahead receive FIFO and sticky line-error flags.
//   Clock    : system clock, rising edge
//   Reset    : asynchronous, active-high; aborts any frame, flushes the FIFO
//   Rxd      : asynchronous serial input, idles high
//   RdEn     : pop the FIFO head (ignored while Empty)
//   RdData   : FIFO head byte (show-ahead)
//   Empty    : FIFO holds no bytes
//   FrameErr : sticky; stop bit sampled low
//   Overrun  : sticky; byte dropped because the FIFO was full
//   ErrClr   : clears both sticky flags; a simultaneous set wins
// -----------------------------------------------------------------------------
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 Rxd,
  input  logic                 RdEn,
  input  logic                 ErrClr,
  output logic [DATA_BITS-1:0] RdData,
  output logic                 Empty,
  output logic                 FrameErr,
  output logic                 Overrun
);

  localparam int DIVISOR = calc_divisor(CLK_FREQ, BAUD_RATE);
  localparam int DIV_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam int TICK_W  = $clog2(OVERSAMPLE);
  localparam int IDX_W   = $clog2(DATA_BITS);

  logic                 r_sync1;
  logic                 r_sync2;
  logic                 w_rxd_s;
  rx_state_t            r_state;
  rx_state_t            w_state_next;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [TICK_W-1:0]    r_tick_cnt;
  logic [TICK_W-1:0]    w_tick_next;
  logic                 r_samp_lo;
  logic                 r_samp_mid;
  logic [IDX_W-1:0]     r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_frame_err;
  logic                 r_overrun;
  logic                 w_run;
  logic                 w_tick;
  logic                 w_decide;
  logic                 w_vote;
  logic                 w_shift_en;
  logic                 w_push;
  logic                 w_ferr_set;
  logic                 w_ovr_set;
  logic                 w_full;

  // ---------------------------------------------------------------------------
  // Input synchronizer; flops reset to the idle (high) line level so reset
  // release never looks like a start edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= Rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxd_s = r_sync2;

  // ---------------------------------------------------------------------------
  // Tick generator and bit-time tick counter. Both are held at zero outside
  // the frame states, so counting restarts exactly when the start edge moves
  // the FSM out of IDLE and all sample points are phase-aligned to that edge.
  // ---------------------------------------------------------------------------
  assign w_run       = (r_state == START) || (r_state == DATA) || (r_state == STOP);
  assign w_tick      = w_run && (r_div_cnt == DIV_W'(DIVISOR - 1));
  assign w_tick_next = r_tick_cnt + TICK_W'(1);
  assign w_decide    = w_tick && (w_tick_next == TICK_W'(SAMPLE_HI));
  // The third vote is the live synchronized sample at the decision tick.
  assign w_vote      = (r_samp_lo & r_samp_mid) | (r_samp_lo & w_rxd_s) |
                       (r_samp_mid & w_rxd_s);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_div_cnt  <= '0;
      r_tick_cnt <= '0;
      r_samp_lo  <= 1'b0;
      r_samp_mid <= 1'b0;
    end else begin
      if (!w_run) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= '0;
      end else if (w_tick) begin
        r_div_cnt  <= '0;
        r_tick_cnt <= w_tick_next;
      end else begin
        r_div_cnt  <= r_div_cnt + DIV_W'(1);
      end
      if (w_tick && (w_tick_next == TICK_W'(SAMPLE_LO))) begin
        r_samp_lo <= w_rxd_s;
      end
      if (w_tick && (w_tick_next == TICK_W'(SAMPLE_LO + 1))) begin
        r_samp_mid <= w_rxd_s;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Receive FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    // NOTE: every signal written here gets a default first; a path that left
    // one unassigned would infer a latch.
    w_state_next = r_state;
    w_shift_en   = 1'b0;
    w_push       = 1'b0;
    w_ferr_set   = 1'b0;
    case (r_state)
      IDLE: begin
        if (!w_rxd_s) begin
          w_state_next = START;
        end
      end
      START: begin
        if (w_decide) begin
          w_state_next = w_vote ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_decide) begin
          w_shift_en = 1'b1;
          if (r_bit_idx == IDX_W'(DATA_BITS - 1)) begin
            w_state_next = STOP;
          end
        end
      end
      STOP: begin
        // Leaving at the stop-bit decision, not its end, leaves half a bit of
        // slack for the next frame's start edge.
        if (w_decide) begin
          if (w_vote) begin
            w_push       = 1'b1;
            w_state_next = IDLE;
          end else begin
            w_ferr_set   = 1'b1;
            w_state_next = BREAK;
          end
        end
      end
      BREAK: begin
        if (w_rxd_s) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // LSB arrives first, so each new bit enters at the top and shifts down.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state != DATA) begin
        r_bit_idx <= '0;
      end else if (w_shift_en) begin
        r_bit_idx <= r_bit_idx + IDX_W'(1);
      end
      if (w_shift_en) begin
        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Sticky error flags; a set in the same cycle as ErrClr wins.
  // ---------------------------------------------------------------------------
  // A full FIFO still takes the byte if the bus pops in the same cycle.
  assign w_ovr_set = w_push && w_full && !RdEn;

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_ferr_set) begin
        r_frame_err <= 1'b1;
      end else if (ErrClr) begin
        r_frame_err <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (ErrClr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign FrameErr = r_frame_err;
  assign Overrun  = r_overrun;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .Clock  (Clock),
    .Reset  (Reset),
    .WrEn   (w_push),
    .WrData (r_shift),
    .RdEn   (RdEn),
    .RdData (RdData),
    .Empty  (Empty),
    .Full   (w_full)
  );

endmodule

// File: tb/tb_uart_receiver.sv
// -----------------------------------------------------------------------------
// tb_uart_receiver
// Drives 8N1 frames onto Rxd at real line timing and keeps a byte-level model
// (queue of expected bytes plus two sticky flags) updated once per frame.
// A compare process checks the DUT against the model on every falling clock
// edge while the line is outside a stop bit; literal checks pin the model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_receiver;

  localparam int  DEPTH  = 4;
  localparam real BIT_NS = 1.0e9 / 115200.0;

  logic       Clock  = 1'b0;
  logic       Reset  = 1'b1;
  logic       Rxd    = 1'b1;
  logic       RdEn   = 1'b0;
  logic       ErrClr = 1'b0;
  logic [7:0] RdData;
  logic       Empty;
  logic       FrameErr;
  logic       Overrun;

  uart_receiver #(
    .CLK_FREQ   (50_000_000),
    .BAUD_RATE  (115200),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .Clock    (Clock),
    .Reset    (Reset),
    .Rxd      (Rxd),
    .RdEn     (RdEn),
    .ErrClr   (ErrClr),
    .RdData   (RdData),
    .Empty    (Empty),
    .FrameErr (FrameErr),
    .Overrun  (Overrun)
  );

  always #10 Clock = ~Clock;

  int          n_vec = 0;
  int          n_err = 0;
  byte unsigned m_q[$];
  bit          m_ferr = 1'b0;
  bit          m_ovr  = 1'b0;
  bit          chk_en = 1'b0;
  int          cyc = 0;
  int          fall_cyc = 0;
  int          empty_fall_cyc = -1;
  logic        prev_empty = 1'b1;
  int          latency = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge Clock) cyc <= cyc + 1;

  // Cycle stamp of the latest Empty fall, for the push-latency measurement.
  always @(negedge Clock) begin
    if (prev_empty === 1'b1 && Empty === 1'b0) empty_fall_cyc <= cyc;
    prev_empty <= Empty;
  end

  always @(negedge Clock) begin
    if (chk_en) begin
      check("cyc_empty", Empty, m_q.size() == 0);
      if (m_q.size() != 0) check("cyc_rddata", RdData, m_q[0]);
      check("cyc_frame_err", FrameErr, m_ferr);
      check("cyc_overrun", Overrun, m_ovr);
    end
  end

  // Byte-level effect of one complete frame.
  task automatic model_frame(input byte unsigned d, input bit stop_ok);
    if (!stop_ok) m_ferr = 1'b1;
    else if (m_q.size() < DEPTH) m_q.push_back(d);
    else m_ovr = 1'b1;
  endtask

  task automatic send_frame(input byte unsigned d, input bit stop_ok, input real bit_ns);
    @(negedge Clock);
    Rxd = 1'b0;
    fall_cyc = cyc;
    #(bit_ns);
    for (int i = 0; i < 8; i++) begin
      Rxd = d[i];
      #(bit_ns);
    end
    chk_en = 1'b0;
    if (stop_ok) begin
      Rxd = 1'b1;
      #(bit_ns);
    end else begin
      Rxd = 1'b0;
      #(2.0 * bit_ns);
      Rxd = 1'b1;
      #(bit_ns);
    end
    model_frame(d, stop_ok);
    chk_en = 1'b1;
  endtask

  task automatic do_read();
    @(negedge Clock);
    RdEn = 1'b1;
    @(posedge Clock);
    #1;
    RdEn = 1'b0;
    if (m_q.size() != 0) void'(m_q.pop_front());
  endtask

  task automatic read_expect(input byte unsigned exp);
    @(negedge Clock);
    check("read_empty", Empty, 1'b0);
    check("read_head", RdData, exp);
    do_read();
  endtask

  task automatic err_clear();
    @(negedge Clock);
    ErrClr = 1'b1;
    @(posedge Clock);
    #1;
    ErrClr = 1'b0;
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
  endtask

  initial begin
    byte unsigned d;
    int           rd_wait;
    real          scale;

    // Reset values
    repeat (3) @(negedge Clock);
    check("rst_empty", Empty, 1'b1);
    check("rst_rddata", RdData, 8'h00);
    check("rst_frame_err", FrameErr, 1'b0);
    check("rst_overrun", Overrun, 1'b0);
    Reset = 1'b0;
    chk_en = 1'b1;
    repeat (20) @(negedge Clock);

    // Single byte and push latency
    send_frame(8'hA5, 1'b1, BIT_NS);
    latency = empty_fall_cyc - fall_cyc;
    check("a5_latency", (latency >= 4128 && latency <= 4134) ? 4131 : latency, 4131);
    @(negedge Clock);
    check("a5_empty", Empty, 1'b0);
    check("a5_data", RdData, 8'hA5);
    do_read();
    @(negedge Clock);
    check("a5_empty_after_read", Empty, 1'b1);

    // Glitch: 100 clocks low is a false start
    @(negedge Clock);
    Rxd = 1'b0;
    repeat (100) @(negedge Clock);
    Rxd = 1'b1;
    repeat (400) @(negedge Clock);
    check("glitch_no_push", Empty, 1'b1);
    check("glitch_flags", {FrameErr, Overrun}, 2'b00);
    send_frame(8'h3C, 1'b1, BIT_NS);
    read_expect(8'h3C);

    // Framing error, recovery, clear
    send_frame(8'h3C, 1'b0, BIT_NS);
    @(negedge Clock);
    check("ferr_set", FrameErr, 1'b1);
    check("ferr_no_push", Empty, 1'b1);
    send_frame(8'h81, 1'b1, BIT_NS);
    read_expect(8'h81);
    err_clear();
    @(negedge Clock);
    check("ferr_cleared", FrameErr, 1'b0);

    // Fill, then pop on the very cycle of the fifth push, then overrun
    for (int v = 1; v <= 4; v++) send_frame(byte'(v), 1'b1, BIT_NS);
    rd_wait = (latency >= 100 && latency <= 6000) ? latency : 4131;
    fork
      send_frame(8'h05, 1'b1, BIT_NS);
      begin
        @(negedge Clock);
        repeat (rd_wait - 2) @(negedge Clock);
        do_read();
      end
    join
    @(negedge Clock);
    check("full_rd_no_overrun", Overrun, 1'b0);
    send_frame(8'h06, 1'b1, BIT_NS);
    @(negedge Clock);
    check("overrun_set", Overrun, 1'b1);
    for (int v = 2; v <= 5; v++) read_expect(byte'(v));
    @(negedge Clock);
    check("overrun_drained", Empty, 1'b1);
    err_clear();
    @(negedge Clock);
    check("overrun_cleared", Overrun, 1'b0);

    // Reset during data bit 4 with a byte already buffered
    send_frame(8'h5A, 1'b1, BIT_NS);
    d = 8'hC3;
    @(negedge Clock);
    Rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 4; i++) begin
      Rxd = d[i];
      #(BIT_NS);
    end
    Rxd = d[4];
    #(BIT_NS / 2.0);
    Reset = 1'b1;
    Rxd = 1'b1;
    m_q.delete();
    m_ferr = 1'b0;
    m_ovr  = 1'b0;
    @(negedge Clock);
    check("midrst_empty", Empty, 1'b1);
    check("midrst_rddata", RdData, 8'h00);
    check("midrst_flags", {FrameErr, Overrun}, 2'b00);
    repeat (4) @(negedge Clock);
    Reset = 1'b0;
    repeat (500) @(negedge Clock);
    check("midrst_no_partial", Empty, 1'b1);
    send_frame(8'hFF, 1'b1, BIT_NS);
    read_expect(8'hFF);

    // Random bytes at up to +/-2.5% baud error, random reads between frames
    for (int k = 0; k < 3; k++) begin
      d = byte'($urandom_range(0, 255));
      scale = 0.975 + 0.05 * real'($urandom_range(0, 1000)) / 1000.0;
      send_frame(d, 1'b1, BIT_NS * scale);
      repeat ($urandom_range(1, 200)) @(negedge Clock);
      if ($urandom_range(0, 1) == 1 && m_q.size() != 0) do_read();
    end
    while (m_q.size() != 0) do_read();
    @(negedge Clock);
    check("final_empty", Empty, 1'b1);

    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
